// File: rtl/main_memory_ctrl_if.sv
// main_memory_ctrl_if -- request/response bundle between the data cache
// controller (master) and the main memory controller (slave).
//   MsRead    : line-fill request
//   MsWrite   : write-through single-word request
//   line_addr : line address {tag[2:0], index[4:0]}
//   word_off  : word within the line (writes only)
//   wdata     : write data
//   rline     : returned line, word 0 in bits [31:0]
//   MsReady   : one-cycle completion pulse
//   busy      : a request is in flight
interface main_memory_ctrl_if;
   logic         MsRead;
   logic         MsWrite;
   logic [7:0]   line_addr;
   logic [1:0]   word_off;
   logic [31:0]  wdata;
   logic [127:0] rline;
   logic         MsReady;
   logic         busy;

   modport master (
      output MsRead, MsWrite, line_addr, word_off, wdata,
      input  rline, MsReady, busy
   );

   modport slave (
      input  MsRead, MsWrite, line_addr, word_off, wdata,
      output rline, MsReady, busy
   );
endinterface

// File: rtl/main_memory_ctrl.sv
// main_memory_ctrl -- fixed-latency main memory model behind the data cache.
// 256 lines x 128 bits. One request at a time: a request is accepted in IDLE,
// waits LATENCY-1 cycles, then spends one cycle in DONE where MsReady pulses.
// Reads return the whole line in DONE; writes merge one word into the line on
// the edge leaving DONE.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-low reset (storage is not cleared)
//   bus  : main_memory_ctrl_if.slave (request in, rline/MsReady/busy out)
//
// Parameters:
//   LATENCY       : acceptance edge to MsReady, 1..15
//   LINE_WORDS    : 32-bit words per line, must be 4
//   PRELOAD_IMAGE : storage image (one 128-bit line per entry), the contents
//                   of "main_mem.hex" as supplied by the build
//
// Build option:
//   MAIN_MEM_PRELOAD_EN : load storage from PRELOAD_IMAGE at time zero;
//                         otherwise all zero.
module main_memory_ctrl #(
   parameter int LATENCY    = 4,
   parameter int LINE_WORDS = 4,
   parameter logic [127:0] PRELOAD_IMAGE [256] = '{default: '0}
) (
   input  logic               clk,
   input  logic               rst,
   main_memory_ctrl_if.slave  bus
);

   localparam int WORD_W = 32;
   localparam int LINE_W = LINE_WORDS * WORD_W;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("main_memory_ctrl: LATENCY must be 1..15");
   end
   if (LINE_WORDS != 4) begin : g_bad_line
      $error("main_memory_ctrl: LINE_WORDS must be 4");
   end

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

   // Captured request; inputs are ignored until the FSM returns to IDLE.
   typedef struct packed {
      logic                wr;
      logic [7:0]          addr;
      logic [1:0]          off;
      logic [WORD_W-1:0]   data;
   } req_t;

   state_t             state;
   logic [3:0]         cnt;
   req_t               req;
   logic               ms_ready_q;
   logic               busy_q;
   logic [LINE_W-1:0]  rline_q;

`ifdef MAIN_MEM_PRELOAD_EN
   logic [LINE_W-1:0]  mem [256];
   initial begin
      for (int i = 0; i < 256; i++)
         mem[i] = PRELOAD_IMAGE[i];
   end
`else
   logic [LINE_W-1:0]  mem [256] = '{default: '0};
`endif

   // Write data merged into the captured line, one lane per word.
   logic [LINE_WORDS-1:0][WORD_W-1:0] cur_line;
   logic [LINE_WORDS-1:0][WORD_W-1:0] wr_line;

   assign cur_line = mem[req.addr];

   for (genvar w = 0; w < LINE_WORDS; w++) begin : g_merge
      assign wr_line[w] = (req.off == 2'(w)) ? req.data : cur_line[w];
   end

   // Control FSM; all outputs registered.
   // The wait states last LATENCY-1 cycles: the counter is loaded with
   // LATENCY-1 and DONE is entered on the edge where it reaches zero, which
   // puts MsReady in the LATENCY-th cycle after acceptance and gives one
   // request per LATENCY+1 cycles (wait + DONE + accepting IDLE cycle).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         req        <= '0;
         ms_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         rline_q    <= '0;
      end else begin
         ms_ready_q <= 1'b0;
         case (state)
            IDLE: begin
               // Write wins when both are high; a held read is taken later.
               if (bus.MsWrite || bus.MsRead) begin
                  req.wr   <= bus.MsWrite;
                  req.addr <= bus.line_addr;
                  req.off  <= bus.word_off;
                  req.data <= bus.wdata;
                  cnt      <= CNT_LOAD;
                  busy_q   <= 1'b1;
                  if (LATENCY == 1) begin
                     state      <= DONE;
                     ms_ready_q <= 1'b1;
                     if (!bus.MsWrite)
                        rline_q <= mem[bus.line_addr];
                  end else begin
                     state <= bus.MsWrite ? WR_WAIT : RD_WAIT;
                  end
               end
            end
            RD_WAIT, WR_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state      <= DONE;
                  ms_ready_q <= 1'b1;
                  if (state == RD_WAIT)
                     rline_q <= mem[req.addr];
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Storage has no reset. A write commits only on the edge leaving DONE, so
   // a reset anywhere before that point drops it.
   always_ff @(posedge clk) begin
      if (rst && state == DONE && req.wr)
         mem[req.addr] <= wr_line;
   end

   assign bus.MsReady = ms_ready_q;
   assign bus.busy    = busy_q;
   assign bus.rline   = rline_q;

endmodule
